data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised data memory for the single-cycle/multicycle CPU datapath.
//  Adds byte/half/word loads and stores, with sign or zero extension.
//  A request/response handshake with programmable wait states models slow memory.
//  Sits on the MEM stage in place of the plain word-only memory; control unit
//  stalls on ready/rvalid.
// PARAMETERS
//  ADDR_W      32   byte-address width
//  DEPTH       256  number of 32-bit words (power of 2, >=4); index = Address[$clog2(DEPTH)+1:2]
//  WAIT_CYCLES 1    extra wait cycles per access, 0..15
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  MemRead     in   1       read request, sampled only when ready=1
//  MemWrite    in   1       write request, sampled only when ready=1
//  Address     in   ADDR_W  byte address
//  WriteData   in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  Size        in   2       00 byte, 01 half, 10 word, 11 treated as word
//  Unsigned    in   1       1 = zero-extend loads, 0 = sign-extend
//  ready       out  1       1 = idle, request accepted this cycle
//  rvalid      out  1       one-cycle pulse, ReadData valid
//  ReadData    out  32      extended load result, held until next rvalid
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, ready=1, rvalid=0, ReadData=0, cnt=0, err=0.
//    Array contents not reset; reset mid-access aborts it, pending write never commits.
//  - FSM IDLE -> WAIT (WAIT_CYCLES>0) -> ACCESS -> IDLE; WAIT_CYCLES=0 skips WAIT.
//  - IDLE: ready=1; on MemRead|MemWrite latch Address, WriteData, Size, Unsigned, op.
//    Both asserted -> write only, read dropped.
//  - WAIT: ready=0; cnt counts 0..WAIT_CYCLES-1; inputs ignored.
//  - ACCESS: ready=0. Write: byte lanes merged into word at the clk edge leaving ACCESS.
//    Read: ReadData registered, rvalid=1 in the following IDLE cycle.
//  - Latency: request accepted at edge T -> rvalid high in cycle after T+1+WAIT_CYCLES;
//    next request may be accepted in that same cycle (back-to-back allowed).
//  - Byte lane = Address[1:0]; half lane = Address[1]. Store merges only addressed lanes.
//  - Load extension: byte from bit 7, half from bit 15 unless Unsigned=1; word passthrough.
//  - Address bits above index range ignored: addresses wrap modulo DEPTH*4.
//  - Misaligned access (half with Address[0]=1, word with Address[1:0]!=0):
//    low bits forced to zero (half uses Address[1] only, word ignores [1:0]).
// CONFIGURATION
//  DMEM_MISALIGN_ERR_EN defined: extra port err out 1.
//    A misaligned access still runs the full FSM timing.
//    Write suppressed (array unchanged); read returns ReadData=0.
//    err=1 for one cycle, coincident with rvalid (read) or the first IDLE cycle (write).
//  Undefined: no err port; forced-alignment behaviour above.
// TESTING
//  1 WAIT_CYCLES=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> ready low 2 cycles per access,
//    rvalid 3 cycles after accept, ReadData=0xDEADBEEF.
//  2 SB 0x80 @0x13 over word 0x11223344, LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080;
//    LW @0x10 -> 0x80223344.
//  3 SH 0xABCD @0x22, LH @0x22 -> 0xFFFFABCD, LHU -> 0x0000ABCD, low half of word intact.
//  4 DEPTH=256: SW 0x5 @0x400, LW @0x000 -> 0x5 (wrap); MemRead+MemWrite together ->
//    write only, no rvalid.
//  5 Reset asserted in WAIT of SW 0x1 @0x8 (old value 0x7) -> outputs reset immediately,
//    LW @0x8 afterwards -> 0x7.
//  6 DMEM_MISALIGN_ERR_EN: LW @0x11 -> rvalid=1, err=1, ReadData=0; SH @0x13 -> err=1,
//    word unchanged. WAIT_CYCLES=0 repeat of test 1: rvalid 2 cycles after accept.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: MEM-stage request/response bus between the CPU datapath and the data memory.
//  master (CPU) drives MemRead, MemWrite, Address, WriteData, Size, Unsigned.
//  slave (memory) drives ready, rvalid, ReadData and, when DMEM_MISALIGN_ERR_EN is defined, err.
interface data_memory_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              MemRead;
   logic              MemWrite;
   logic [ADDR_W-1:0] Address;
   logic [31:0]       WriteData;
   logic [1:0]        Size;
   logic              Unsigned;
   logic              ready;
   logic              rvalid;
   logic [31:0]       ReadData;
`ifdef DMEM_MISALIGN_ERR_EN
   logic              err;
   modport master (output MemRead, MemWrite, Address, WriteData, Size, Unsigned,
                   input ready, rvalid, ReadData, err);
   modport slave  (input MemRead, MemWrite, Address, WriteData, Size, Unsigned,
                   output ready, rvalid, ReadData, err);
`else
   modport master (output MemRead, MemWrite, Address, WriteData, Size, Unsigned,
                   input ready, rvalid, ReadData);
   modport slave  (input MemRead, MemWrite, Address, WriteData, Size, Unsigned,
                   output ready, rvalid, ReadData);
`endif
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte/half/word data memory with sign/zero-extended loads and programmable wait states.
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset
//  bus    data_memory_ctrl_if.slave: MemRead/MemWrite/Address/WriteData/Size/Unsigned in,
//         ready/rvalid/ReadData out (plus err when DMEM_MISALIGN_ERR_EN is defined).
//  Optional feature macro: DMEM_MISALIGN_ERR_EN -- misaligned accesses are suppressed and flagged on err
//  instead of being force-aligned.
module data_memory_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input logic               clk,
   input logic               rst_n,
   data_memory_ctrl_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
   state_t      state;
   logic [3:0]  cnt;
   logic        ready_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        wr_q;
   logic [IW+1:0] a_q;
   logic [31:0] wd_q;
   logic [1:0]  sz_q;
   logic        un_q;
   logic [31:0] mem [DEPTH];
   logic [IW-1:0] idx;
   logic [1:0]  el;
   logic [3:0]  be;
   logic [31:0] rw;
   logic [31:0] sh;
   logic [31:0] ld;
   logic [31:0] wl;
   logic        mis;
   logic        we;
   logic        req;
   logic        unused_addr;
   assign unused_addr = ^bus.Address[ADDR_W-1:IW+2];
   assign req = bus.MemRead | bus.MemWrite;
   assign idx = a_q[IW+1:2];
   // Force alignment: halves use Address[1] only, words ignore [1:0].
   assign el  = sz_q == 2'b00 ? a_q[1:0] : sz_q == 2'b01 ? {a_q[1], 1'b0} : 2'b00;
   assign be  = sz_q == 2'b00 ? 4'b0001 << el : sz_q == 2'b01 ? (el[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wl  = sz_q == 2'b00 ? {4{wd_q[7:0]}} : sz_q == 2'b01 ? {2{wd_q[15:0]}} : wd_q;
   assign rw  = mem[idx];
   assign sh  = rw >> {el, 3'b000};
   assign ld  = sz_q == 2'b00 ? {{24{~un_q & sh[7]}}, sh[7:0]} :
                sz_q == 2'b01 ? {{16{~un_q & sh[15]}}, sh[15:0]} : rw;
`ifdef DMEM_MISALIGN_ERR_EN
   assign mis = (sz_q == 2'b01 & a_q[0]) | (sz_q[1] & |a_q[1:0]);
   assign bus.err = err_q;
`else
   assign mis = 1'b0;
`endif
   assign we = state == S_ACCESS & wr_q & ~mis;
   assign bus.ready    = ready_q;
   assign bus.rvalid   = rvalid_q;
   assign bus.ReadData = rdata_q;
   // Request capture; write wins when both MemRead and MemWrite are high.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && req) begin
         wr_q <= bus.MemWrite;
         a_q  <= bus.Address[IW+1:0];
         wd_q <= bus.WriteData;
         sz_q <= bus.Size;
         un_q <= bus.Unsigned;
      end
   end
   // Only the addressed byte lanes are written.
   always_ff @(posedge clk) begin
      if (we)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wl[8*i +: 8];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               rvalid_q <= 1'b0;
               err_q    <= 1'b0;
               if (req) begin
                  ready_q <= 1'b0;
                  cnt     <= '0;
                  state   <= WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               if (cnt == 4'(WAIT_CYCLES - 1)) state <= S_ACCESS;
               else cnt <= cnt + 4'd1;
            end
            S_ACCESS: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
               err_q   <= mis;
               if (!wr_q) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= mis ? 32'h0 : ld;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
